// File: rtl/npu_pkg.sv
// ============================================================================
//  Module   : npu_pkg
//  Purpose  : Shared types and derivation helpers for the chunk feed path.
//             - feed_state_e : read-side sequencer states (IDLE/START/RUN)
//             - calc_wr_cyc_num       : beats per chunk bank
//             - calc_rd_sparsemap_num : sparsemap words per chunk bank
//             - idx_width             : index width for a count of items
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package npu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } feed_state_e;

   // Beats needed to fill one chunk bank.
   function automatic int calc_wr_cyc_num(input int mem_size, input int bus_size);
      return mem_size / bus_size;
   endfunction

   // Sparsemap words the compute unit reads per chunk.
   function automatic int calc_rd_sparsemap_num(input int mem_size, input int prefix_sum_size);
      return mem_size / prefix_sum_size;
   endfunction

   // Width of an index into n items; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bank_writer.sv
// ============================================================================
//  Module   : bank_writer
//  Purpose  : Write side of one operand (IFM or filter) into a two-bank
//             ping-pong buffer. Accepts valid/ready beats, registers each
//             accepted beat as a write strobe, counts beats per chunk,
//             alternates banks and tracks per-bank full flags.
//  Ports    : i_clk, i_rst          clock, synchronous active-high reset
//             i_valid / o_ready     beat handshake
//             i_sparsemap, i_data   beat payload
//             i_release, i_release_bank  free a bank (compute finished)
//             o_sparsemap, o_data, o_wr_valid, o_wr_count, o_wr_sel
//                                   registered write beat to the buffer
//             o_full                current full flags
//             o_full_nxt            full flags being loaded at this edge
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_writer
   import npu_pkg::*;
#(
   parameter  int BUS_SIZE   = 32,
   parameter  int WR_CYC_NUM = 4,
   localparam int CNT_W      = idx_width(WR_CYC_NUM)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [BUS_SIZE-1:0]   i_sparsemap,
   input  logic [BUS_SIZE*8-1:0] i_data,
   input  logic                  i_release,
   input  logic                  i_release_bank,
   output logic [BUS_SIZE-1:0]   o_sparsemap,
   output logic [BUS_SIZE*8-1:0] o_data,
   output logic                  o_wr_valid,
   output logic [CNT_W-1:0]      o_wr_count,
   output logic                  o_wr_sel,
   output logic [1:0]            o_full,
   output logic [1:0]            o_full_nxt
);

   logic [CNT_W-1:0]      r_count;
   logic                  r_wr_sel;
   logic [1:0]            r_full;
   logic                  r_set_pend;
   logic                  r_wr_valid;
   logic [CNT_W-1:0]      r_wr_count;
   logic                  r_wr_bank;
   logic [BUS_SIZE-1:0]   r_sparsemap;
   logic [BUS_SIZE*8-1:0] r_data;

   logic                  w_accept;
   logic                  w_last;
   logic [1:0]            w_full_nxt;

   assign o_ready  = ~r_full[r_wr_sel];
   assign w_accept = i_valid & o_ready;
   assign w_last   = (r_count == CNT_W'(WR_CYC_NUM - 1));

   // The full flag of a bank is raised one edge after its last beat was
   // accepted, i.e. together with the final write strobe leaving this block,
   // so the buffer holds the whole chunk before anyone can start on it.
   // Release and set never target the same bank: a bank is only written
   // while it is empty, and only a full bank is ever released.
   always_comb begin
      w_full_nxt = r_full;
      if (i_release) begin
         w_full_nxt[i_release_bank] = 1'b0;
      end
      if (r_set_pend) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count     <= '0;
         r_wr_sel    <= 1'b0;
         r_full      <= '0;
         r_set_pend  <= 1'b0;
         r_wr_valid  <= 1'b0;
         r_wr_count  <= '0;
         r_wr_bank   <= 1'b0;
         r_sparsemap <= '0;
         r_data      <= '0;
      end else begin
         r_wr_valid <= w_accept;
         r_set_pend <= w_accept & w_last;
         r_full     <= w_full_nxt;
         if (w_accept) begin
            r_sparsemap <= i_sparsemap;
            r_data      <= i_data;
            r_wr_count  <= r_count;
            r_wr_bank   <= r_wr_sel;
            if (w_last) begin
               // Switching banks here means o_ready already reflects the
               // other bank in the cycle the final write goes out.
               r_count  <= '0;
               r_wr_sel <= ~r_wr_sel;
            end else begin
               r_count <= r_count + CNT_W'(1);
            end
         end
      end
   end

   assign o_sparsemap = r_sparsemap;
   assign o_data      = r_data;
   assign o_wr_valid  = r_wr_valid;
   assign o_wr_count  = r_wr_count;
   assign o_wr_sel    = r_wr_bank;
   assign o_full      = r_full;
   assign o_full_nxt  = w_full_nxt;

endmodule

`default_nettype wire

// File: rtl/chunk_feed_ctrl.sv
// ============================================================================
//  Module   : chunk_feed_ctrl
//  Purpose  : Upstream feeder for the compute unit. Streams IFM and filter
//             chunks into two-bank operand buffers and sequences the compute
//             unit: a chunk is started once both operands hold it in the same
//             bank, and that bank is freed when the compute unit signals end.
//  Ports    : clk_i, rst_i                      clock, sync active-high reset
//             ifm_*_i / filter_*_i              beat streams (valid/ready)
//             cfg_rd_sparsemap_last_i           captured at each chunk start
//             ifm_* / filter_* write outputs    registered buffer writes
//             ifm_rd_sel_o, filter_rd_sel_o     bank under computation
//             run_valid_o, chunk_start_o        compute unit control
//             rd_sparsemap_last_o               captured config value
//             chunk_end_i                       compute unit finished chunk
//             busy_o                            any bank full or compute active
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chunk_feed_ctrl
   import npu_pkg::*;
#(
   parameter  int BUS_SIZE         = 32,
   parameter  int MEM_SIZE         = 128,
   parameter  int PREFIX_SUM_SIZE  = 16,
   // Beats per chunk; the bank toggle scheme needs at least two.
   localparam int WR_CYC_NUM       = calc_wr_cyc_num(MEM_SIZE, BUS_SIZE),
   localparam int RD_SPARSEMAP_NUM = calc_rd_sparsemap_num(MEM_SIZE, PREFIX_SUM_SIZE),
   localparam int CNT_W            = idx_width(WR_CYC_NUM),
   localparam int RDL_W            = idx_width(RD_SPARSEMAP_NUM)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // IFM beat stream
   input  logic                  ifm_valid_i,
   output logic                  ifm_ready_o,
   input  logic [BUS_SIZE-1:0]   ifm_sparsemap_i,
   input  logic [BUS_SIZE*8-1:0] ifm_data_i,
   // filter beat stream
   input  logic                  filter_valid_i,
   output logic                  filter_ready_o,
   input  logic [BUS_SIZE-1:0]   filter_sparsemap_i,
   input  logic [BUS_SIZE*8-1:0] filter_data_i,
   // configuration
   input  logic [RDL_W-1:0]      cfg_rd_sparsemap_last_i,
   // IFM buffer write side
   output logic [BUS_SIZE-1:0]   ifm_sparsemap_o,
   output logic [BUS_SIZE*8-1:0] ifm_nonzero_data_o,
   output logic                  ifm_wr_valid_o,
   output logic [CNT_W-1:0]      ifm_wr_count_o,
   output logic                  ifm_wr_sel_o,
   output logic                  ifm_rd_sel_o,
   // filter buffer write side
   output logic [BUS_SIZE-1:0]   filter_sparsemap_o,
   output logic [BUS_SIZE*8-1:0] filter_nonzero_data_o,
   output logic                  filter_wr_valid_o,
   output logic [CNT_W-1:0]      filter_wr_count_o,
   output logic                  filter_wr_sel_o,
   output logic                  filter_rd_sel_o,
   // compute unit control
   output logic                  run_valid_o,
   output logic                  chunk_start_o,
   output logic [RDL_W-1:0]      rd_sparsemap_last_o,
   input  logic                  chunk_end_i,
   output logic                  busy_o
);

   feed_state_e      r_state;
   feed_state_e      w_state_nxt;
   logic             r_rd_sel;
   logic [RDL_W-1:0] r_rd_sparsemap_last;

   logic             w_release;
   logic             w_chunk_start;
   logic             w_run_valid;
   logic [1:0]       w_ifm_full;
   logic [1:0]       w_ifm_full_nxt;
   logic [1:0]       w_flt_full;
   logic [1:0]       w_flt_full_nxt;

   // A chunk is finished only by an end strobe that arrives while running.
   assign w_release = (r_state == ST_RUN) && chunk_end_i;

   bank_writer #(
      .BUS_SIZE   (BUS_SIZE),
      .WR_CYC_NUM (WR_CYC_NUM)
   ) u_ifm_writer (
      .i_clk          (clk_i),
      .i_rst          (rst_i),
      .i_valid        (ifm_valid_i),
      .o_ready        (ifm_ready_o),
      .i_sparsemap    (ifm_sparsemap_i),
      .i_data         (ifm_data_i),
      .i_release      (w_release),
      .i_release_bank (r_rd_sel),
      .o_sparsemap    (ifm_sparsemap_o),
      .o_data         (ifm_nonzero_data_o),
      .o_wr_valid     (ifm_wr_valid_o),
      .o_wr_count     (ifm_wr_count_o),
      .o_wr_sel       (ifm_wr_sel_o),
      .o_full         (w_ifm_full),
      .o_full_nxt     (w_ifm_full_nxt)
   );

   bank_writer #(
      .BUS_SIZE   (BUS_SIZE),
      .WR_CYC_NUM (WR_CYC_NUM)
   ) u_filter_writer (
      .i_clk          (clk_i),
      .i_rst          (rst_i),
      .i_valid        (filter_valid_i),
      .o_ready        (filter_ready_o),
      .i_sparsemap    (filter_sparsemap_i),
      .i_data         (filter_data_i),
      .i_release      (w_release),
      .i_release_bank (r_rd_sel),
      .o_sparsemap    (filter_sparsemap_o),
      .o_data         (filter_nonzero_data_o),
      .o_wr_valid     (filter_wr_valid_o),
      .o_wr_count     (filter_wr_count_o),
      .o_wr_sel       (filter_wr_sel_o),
      .o_full         (w_flt_full),
      .o_full_nxt     (w_flt_full_nxt)
   );

   // Read sequencer. The IDLE decision looks at the flag values being
   // loaded on this edge so that START coincides with the first cycle in
   // which both full flags of the read bank read as set. Leaving RUN always
   // passes through IDLE, giving the one-cycle gap between chunks.
   always_comb begin
      w_state_nxt   = r_state;
      w_chunk_start = 1'b0;
      w_run_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ifm_full_nxt[r_rd_sel] && w_flt_full_nxt[r_rd_sel]) begin
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            w_chunk_start = 1'b1;
            w_run_valid   = 1'b1;
            w_state_nxt   = ST_RUN;
         end
         ST_RUN: begin
            w_run_valid = 1'b1;
            if (chunk_end_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state             <= ST_IDLE;
         r_rd_sel            <= 1'b0;
         r_rd_sparsemap_last <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_release) begin
            r_rd_sel <= ~r_rd_sel;
         end
         // Captured on entry to START so the value is stable alongside the
         // start pulse and for the whole chunk.
         if ((r_state == ST_IDLE) && (w_state_nxt == ST_START)) begin
            r_rd_sparsemap_last <= cfg_rd_sparsemap_last_i;
         end
      end
   end

   assign ifm_rd_sel_o        = r_rd_sel;
   assign filter_rd_sel_o     = r_rd_sel;
   assign chunk_start_o       = w_chunk_start;
   assign run_valid_o         = w_run_valid;
   assign rd_sparsemap_last_o = r_rd_sparsemap_last;
   assign busy_o              = (|w_ifm_full) | (|w_flt_full) | (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_chunk_feed_ctrl.sv
// ============================================================================
//  Module   : tb_chunk_feed_ctrl
//  Purpose  : Self-checking bench for chunk_feed_ctrl (BUS_SIZE=32,
//             MEM_SIZE=128, four beats per chunk). A transaction-level model
//             predicts every output each cycle from beat counts and the cycle
//             numbers at which chunks complete, start and end.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_chunk_feed_ctrl;

   localparam int MAXCH = 512;
   localparam int INF   = 1 << 30;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         ifm_valid_i, filter_valid_i, chunk_end_i;
   logic         ifm_ready_o, filter_ready_o;
   logic [31:0]  ifm_sparsemap_i, filter_sparsemap_i;
   logic [255:0] ifm_data_i, filter_data_i;
   logic [2:0]   cfg_rd_sparsemap_last_i;
   logic [31:0]  ifm_sparsemap_o, filter_sparsemap_o;
   logic [255:0] ifm_nonzero_data_o, filter_nonzero_data_o;
   logic         ifm_wr_valid_o, filter_wr_valid_o;
   logic [1:0]   ifm_wr_count_o, filter_wr_count_o;
   logic         ifm_wr_sel_o, filter_wr_sel_o, ifm_rd_sel_o, filter_rd_sel_o;
   logic         run_valid_o, chunk_start_o, busy_o;
   logic [2:0]   rd_sparsemap_last_o;

   always #5 clk_i = ~clk_i;

   chunk_feed_ctrl #(.BUS_SIZE(32), .MEM_SIZE(128), .PREFIX_SUM_SIZE(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ifm_valid_i(ifm_valid_i), .ifm_ready_o(ifm_ready_o),
      .ifm_sparsemap_i(ifm_sparsemap_i), .ifm_data_i(ifm_data_i),
      .filter_valid_i(filter_valid_i), .filter_ready_o(filter_ready_o),
      .filter_sparsemap_i(filter_sparsemap_i), .filter_data_i(filter_data_i),
      .cfg_rd_sparsemap_last_i(cfg_rd_sparsemap_last_i),
      .ifm_sparsemap_o(ifm_sparsemap_o), .ifm_nonzero_data_o(ifm_nonzero_data_o),
      .ifm_wr_valid_o(ifm_wr_valid_o), .ifm_wr_count_o(ifm_wr_count_o),
      .ifm_wr_sel_o(ifm_wr_sel_o), .ifm_rd_sel_o(ifm_rd_sel_o),
      .filter_sparsemap_o(filter_sparsemap_o), .filter_nonzero_data_o(filter_nonzero_data_o),
      .filter_wr_valid_o(filter_wr_valid_o), .filter_wr_count_o(filter_wr_count_o),
      .filter_wr_sel_o(filter_wr_sel_o), .filter_rd_sel_o(filter_rd_sel_o),
      .run_valid_o(run_valid_o), .chunk_start_o(chunk_start_o),
      .rd_sparsemap_last_o(rd_sparsemap_last_o), .chunk_end_i(chunk_end_i),
      .busy_o(busy_o)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- reference model state ----------------
   int           mc;                 // cycle number since last reset
   int           m_nacc [2];         // beats accepted per operand
   int           m_ff   [2][MAXCH];  // cycle from which chunk k reads as full
   int           m_rel  [MAXCH];     // cycle from which chunk k is freed
   int           m_nstart;           // chunks started so far
   bit           m_act;              // a chunk is in START/RUN
   int           m_st, m_endp;       // start cycle of current chunk, last end cycle
   int           m_rdl, m_cfgp;      // expected latched cfg, cfg of previous cycle
   bit           m_pw   [2];         // a write strobe is due this cycle
   int           m_pc   [2], m_ps [2];
   logic [255:0] m_pd   [2];
   logic [31:0]  m_psm  [2];

   // ---------------- per-cycle snapshot of DUT outputs ----------------
   bit           s_irdy, s_frdy, s_iwv, s_fwv, s_isel, s_cs, s_rv, s_rds, s_busy, s_any;
   int           s_icnt;
   logic [255:0] s_idata;
   logic [2:0]   s_rdl;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, mc, act, exp);
      end
   endtask

   task automatic model_reset();
      mc = 0; m_nstart = 0; m_act = 0; m_st = 0; m_endp = -100; m_rdl = 0; m_cfgp = 0;
      for (int o = 0; o < 2; o++) begin
         m_nacc[o] = 0; m_pw[o] = 0;
         for (int k = 0; k < MAXCH; k++) m_ff[o][k] = INF;
      end
      for (int k = 0; k < MAXCH; k++) m_rel[k] = INF;
   endtask

   function automatic bit is_full(input int o, input int k);
      if (k < 0 || k >= MAXCH) return 1'b0;
      return (m_ff[o][k] <= mc) && (mc < m_rel[k]);
   endfunction

   task automatic model_cycle();
      bit erdy [2];
      bit ebusy;
      bit vld  [2];
      bit  a_wv [2];
      int  a_cnt [2];
      bit  a_sel [2];
      logic [255:0] a_d [2];
      logic [31:0]  a_sm [2];
      string nm [2];
      nm[0] = "ifm"; nm[1] = "filter";
      a_wv[0] = ifm_wr_valid_o;        a_wv[1] = filter_wr_valid_o;
      a_cnt[0] = int'(ifm_wr_count_o); a_cnt[1] = int'(filter_wr_count_o);
      a_sel[0] = ifm_wr_sel_o;         a_sel[1] = filter_wr_sel_o;
      a_d[0] = ifm_nonzero_data_o;     a_d[1] = filter_nonzero_data_o;
      a_sm[0] = ifm_sparsemap_o;       a_sm[1] = filter_sparsemap_o;
      vld[0] = ifm_valid_i;            vld[1] = filter_valid_i;

      // chunk j starts once both operands hold it and one idle cycle followed the last end
      if (!m_act && m_nstart < MAXCH && m_ff[0][m_nstart] <= mc &&
          m_ff[1][m_nstart] <= mc && mc >= m_endp + 2) begin
         m_act = 1; m_st = mc; m_rdl = m_cfgp; m_nstart++;
      end
      ebusy = m_act;
      for (int o = 0; o < 2; o++) begin
         erdy[o] = !is_full(o, m_nacc[o] / 4 - 2);   // same bank, two chunks back
         for (int k = m_nstart - 2; k <= m_nstart + 1; k++) if (is_full(o, k)) ebusy = 1;
      end

      chk("ifm_ready", ifm_ready_o, erdy[0]);
      chk("filter_ready", filter_ready_o, erdy[1]);
      chk("chunk_start", chunk_start_o, m_act && (mc == m_st));
      chk("run_valid", run_valid_o, m_act);
      chk("rd_sel", {ifm_rd_sel_o, filter_rd_sel_o}, {2{1'((m_nstart - int'(m_act)) % 2)}});
      chk("busy", busy_o, ebusy);
      chk("rd_sparsemap_last", rd_sparsemap_last_o, m_rdl);
      for (int o = 0; o < 2; o++) begin
         chk({nm[o], "_wr_valid"}, a_wv[o], m_pw[o]);
         if (m_pw[o]) begin
            chk({nm[o], "_wr_count"}, a_cnt[o], m_pc[o]);
            chk({nm[o], "_wr_sel"}, a_sel[o], m_ps[o]);
            chk({nm[o], "_data"}, a_d[o], m_pd[o]);
            chk({nm[o], "_sparsemap"}, a_sm[o], m_psm[o]);
         end
      end

      // effects of this cycle's inputs
      for (int o = 0; o < 2; o++) begin
         m_pw[o] = vld[o] && erdy[o];
         if (m_pw[o]) begin
            m_pc[o]  = m_nacc[o] % 4;
            m_ps[o]  = (m_nacc[o] / 4) % 2;
            m_pd[o]  = (o == 0) ? ifm_data_i : filter_data_i;
            m_psm[o] = (o == 0) ? ifm_sparsemap_i : filter_sparsemap_i;
            if (m_nacc[o] % 4 == 3 && m_nacc[o] / 4 < MAXCH) m_ff[o][m_nacc[o] / 4] = mc + 2;
            m_nacc[o]++;
         end
      end
      if (chunk_end_i && m_act && mc > m_st) begin
         m_rel[m_nstart - 1] = mc + 1;
         m_act  = 0;
         m_endp = mc;
      end
      m_cfgp = int'(cfg_rd_sparsemap_last_i);
      mc++;
   endtask

   // One clock cycle: drive inputs, sample and check at the falling edge.
   task automatic step(input bit iv, input bit fv, input bit ce, input logic [2:0] cfg, input bit rst);
      logic [255:0] d0, d1;
      for (int i = 0; i < 8; i++) begin
         d0[i*32 +: 32] = $urandom;
         d1[i*32 +: 32] = $urandom;
      end
      d0[7:0] = 8'(m_nacc[0] % 4);
      d1[7:0] = 8'(m_nacc[1] % 4);
      rst_i = rst; ifm_valid_i = iv; filter_valid_i = fv; chunk_end_i = ce;
      cfg_rd_sparsemap_last_i = cfg;
      ifm_data_i = d0; filter_data_i = d1;
      ifm_sparsemap_i = $urandom; filter_sparsemap_i = $urandom;
      @(negedge clk_i);
      s_irdy = ifm_ready_o; s_frdy = filter_ready_o; s_iwv = ifm_wr_valid_o;
      s_fwv = filter_wr_valid_o; s_isel = ifm_wr_sel_o; s_icnt = int'(ifm_wr_count_o);
      s_idata = ifm_nonzero_data_o; s_cs = chunk_start_o; s_rv = run_valid_o;
      s_rds = ifm_rd_sel_o; s_busy = busy_o; s_rdl = rd_sparsemap_last_o;
      s_any = (|ifm_sparsemap_o) | (|ifm_nonzero_data_o) | ifm_wr_valid_o | (|ifm_wr_count_o) |
              ifm_wr_sel_o | ifm_rd_sel_o | (|filter_sparsemap_o) | (|filter_nonzero_data_o) |
              filter_wr_valid_o | (|filter_wr_count_o) | filter_wr_sel_o | filter_rd_sel_o |
              run_valid_o | chunk_start_o | (|rd_sparsemap_last_o) | busy_o;
      if (!rst) model_cycle();
      @(posedge clk_i);
      #1;
      if (rst) model_reset();
   endtask

   typedef struct {
      bit iv, fv, ce; int rep;
      bit rdy, wv; int cnt; bit cs, rv, rds, busy;
   } vec_t;
   vec_t tbl [10];

   initial begin
      int base0, base1, ends, seen_bp, t_last_f, t_start;
      bit found;

      // single chunk from reset: beats in cycles 1..4, end strobe in cycle 20
      //         iv fv ce rep rdy wv cnt cs rv rds busy
      tbl[0] = '{0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0};
      tbl[1] = '{1, 1, 0, 1,  1, 0, 0, 0, 0, 0, 0};
      tbl[2] = '{1, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0};
      tbl[3] = '{1, 1, 0, 1,  1, 1, 1, 0, 0, 0, 0};
      tbl[4] = '{1, 1, 0, 1,  1, 1, 2, 0, 0, 0, 0};
      tbl[5] = '{0, 0, 0, 1,  1, 1, 3, 0, 0, 0, 0};
      tbl[6] = '{0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 1};
      tbl[7] = '{0, 0, 0, 13, 1, 0, 0, 0, 1, 0, 1};
      tbl[8] = '{0, 0, 1, 1,  1, 0, 0, 0, 1, 0, 1};
      tbl[9] = '{0, 0, 0, 2,  1, 0, 0, 0, 0, 1, 0};

      model_reset();
      step(0, 0, 0, 3'd0, 1);
      step(0, 0, 0, 3'd0, 1);

      for (int r = 0; r < 10; r++) begin
         for (int n = 0; n < tbl[r].rep; n++) begin
            step(tbl[r].iv, tbl[r].fv, tbl[r].ce, 3'd0, 0);
            chk($sformatf("tbl_row%0d_ctrl", r),
                {s_irdy, s_frdy, s_iwv, s_fwv, s_cs, s_rv, s_rds, s_busy},
                {tbl[r].rdy, tbl[r].rdy, tbl[r].wv, tbl[r].wv, tbl[r].cs, tbl[r].rv, tbl[r].rds, tbl[r].busy});
            if (tbl[r].wv)
               chk($sformatf("tbl_row%0d_beat", r), {s_icnt[1:0], s_isel, s_idata[7:0]},
                   {2'(tbl[r].cnt), 1'b0, 8'(tbl[r].cnt)});
         end
      end

      // spurious end strobes in IDLE, then a chunk with config 3 changed to 1 mid-run
      step(0, 0, 1, 3'd3, 0);
      step(0, 0, 1, 3'd3, 0);
      chk("spurious_rd_sel", s_rds, 1'b1);
      chk("spurious_busy", s_busy, 1'b0);
      for (int i = 0; i < 4; i++) step(1, 1, (i == 1), 3'd3, 0);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(0, 0, 0, 3'd3, 0);
         found = s_cs;
      end
      chk("cfg_start_seen", found, 1'b1);
      chk("cfg_latched_at_start", s_rdl, 3'd3);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 3'd1, 0);
      chk("cfg_held_in_run", s_rdl, 3'd3);
      step(0, 0, 1, 3'd1, 0);
      step(0, 0, 0, 3'd1, 0);

      // skew: filter beats arrive ten cycles after the IFM beats
      for (int i = 0; i < 14; i++) begin
         step(i < 4, i >= 10, 0, 3'd2, 0);
         if (i == 13) t_last_f = mc - 1;
      end
      found = 0; t_start = -1;
      for (int i = 0; i < 10 && !found; i++) begin
         if (s_cs) begin found = 1; t_start = mc - 1; end
         else step(0, 0, 0, 3'd2, 0);
      end
      chk("skew_start_cycle", t_start, t_last_f + 2);
      step(0, 0, 1, 3'd2, 0);
      step(0, 0, 0, 3'd2, 0);

      // ping-pong: three chunks streamed back to back, end 30 cycles after each start
      step(0, 0, 0, 3'd0, 1);
      base0 = m_nacc[0]; base1 = m_nacc[1]; ends = 0; seen_bp = 0;
      for (int i = 0; i < 400 && ends < 3; i++) begin
         bit ce;
         ce = m_act && (mc - m_st == 30);
         if (ce) ends++;
         step(m_nacc[0] < base0 + 12, m_nacc[1] < base1 + 12, ce, 3'(i), 0);
         if (!s_irdy && !s_frdy) seen_bp++;
      end
      chk("pp_all_chunks_done", ends, 3);
      chk("pp_backpressure_seen", seen_bp > 0, 1'b1);
      step(0, 0, 0, 3'd0, 0);
      step(0, 0, 0, 3'd0, 0);

      // randomized traffic with varying density and random end strobes
      step(0, 0, 0, 3'd0, 1);
      for (int blk = 0; blk < 12; blk++) begin
         int di, df;
         di = $urandom_range(1, 8);
         df = $urandom_range(1, 8);
         for (int i = 0; i < 100; i++)
            step(($urandom_range(0, 7) < di) && (m_nacc[0] / 4 < MAXCH - 4),
                 ($urandom_range(0, 7) < df) && (m_nacc[1] / 4 < MAXCH - 4),
                 $urandom_range(0, 9) == 0, 3'($urandom), 0);
      end

      // reset while running with bank 1 half written
      step(0, 0, 0, 3'd5, 1);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 3'd5, 0);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(0, 0, 0, 3'd5, 0);
         found = m_act && s_rv;
      end
      chk("rst_reached_run", found, 1'b1);
      step(1, 0, 0, 3'd5, 0);
      step(1, 0, 0, 3'd5, 0);
      step(0, 0, 0, 3'd5, 1);
      step(1, 1, 0, 3'd0, 0);
      chk("rst_outputs_zero", s_any, 1'b0);
      chk("rst_ready", {s_irdy, s_frdy}, 2'b11);
      step(0, 0, 0, 3'd0, 0);
      chk("rst_restart_beat", {s_iwv, s_icnt[1:0], s_isel}, {1'b1, 2'd0, 1'b0});
      for (int i = 0; i < 4; i++) step(0, 0, 0, 3'd0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/chunk_feed_ctrl.md
Name: chunk_feed_ctrl

Overview:
- Upstream feeder for the compute unit. Accepts IFM and filter chunks as valid/ready beat streams and writes them into the compute unit's ping-pong (two-bank) operand buffers.
- Tracks bank-full state per operand and bank.
- Sequences chunk_start/run_valid for the compute unit and frees the bank on chunk_end.
- Sits between the chunk DMA/compressor and the compute unit. Writing one bank overlaps computation on the other.

Parameters:
- BUS_SIZE, `BUS_SIZE, bytes per write beat (sparsemap bits per beat).
- MEM_SIZE, `MEM_SIZE, bytes per chunk bank.
- WR_CYC_NUM, MEM_SIZE/BUS_SIZE (localparam), beats per chunk; must be ≥2.
- RD_SPARSEMAP_NUM, MEM_SIZE/`PREFIX_SUM_SIZE (localparam), sparsemap words per chunk.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ifm_valid_i  in  1  IFM beat valid
- ifm_ready_o  out  1  IFM beat accepted when valid&ready
- ifm_sparsemap_i  in  BUS_SIZE  IFM beat sparsemap
- ifm_data_i  in  BUS_SIZE×8  IFM beat nonzero data
- filter_valid_i / filter_ready_o / filter_sparsemap_i / filter_data_i  same as the IFM ports, for the filter
- cfg_rd_sparsemap_last_i  in  clog2(RD_SPARSEMAP_NUM)  last sparsemap index; sampled at chunk start
- ifm_sparsemap_o, ifm_nonzero_data_o  out  BUS_SIZE, BUS_SIZE×8  registered write beat
- ifm_wr_valid_o  out  1  write strobe
- ifm_wr_count_o  out  clog2(WR_CYC_NUM)  beat index within the chunk
- ifm_wr_sel_o  out  1  bank being written
- ifm_rd_sel_o  out  1  bank being read
- filter_* write outputs  out  same widths as the IFM write outputs
- run_valid_o  out  1  compute enable
- chunk_start_o  out  1  one-cycle chunk start pulse
- rd_sparsemap_last_o  out  clog2(RD_SPARSEMAP_NUM)  latched cfg value
- chunk_end_i  in  1  compute unit finished chunk
- busy_o  out  1  any bank full or compute running

Behaviour:
- Reset: all outputs 0; both full flags per operand 0; wr_sel=rd_sel=0; beat counters 0; FSM IDLE. Reset mid-chunk discards all data.
- Write side, per operand, independent:
  - ready_o = !full[wr_sel].
  - Accepted beat in cycle T → at T+1: wr_valid_o=1, wr_count_o=counter, data/sparsemap registered, wr_sel_o = bank written.
  - Counter increments per accepted beat. On beat WR_CYC_NUM-1: counter wraps to 0 and wr_sel toggles at the T edge. Consequently ready_o at T+1 reflects the other bank.
  - The full flag of the just-written bank is set at the T+1 edge, visible from T+2, so the last write lands before any start.
  - wr_valid_o is 0 in any cycle with no accepted beat.
- Read FSM states IDLE, START, RUN:
  - IDLE → START when full_ifm[rd_sel] && full_filter[rd_sel].
  - START, one cycle: chunk_start_o=1, run_valid_o=1, rd_sparsemap_last_o latched from cfg_rd_sparsemap_last_i. Always → RUN.
  - RUN: run_valid_o=1. On chunk_end_i, in the same edge:
    - clear full_ifm[rd_sel] and full_filter[rd_sel];
    - toggle rd_sel (ifm_rd_sel_o and filter_rd_sel_o are always equal);
    - → IDLE, so run_valid_o=0 next cycle.
  - chunk_end_i outside RUN is ignored.
  - Back-to-back chunks: minimum one IDLE cycle between RUN end and the next START.
- Simultaneous set/clear targets different banks by construction (writes never target a full bank). The freed bank's ready_o rises the cycle after chunk_end_i.
- Both banks full and RUN active: both ready_o=0 (back-pressure), no data loss.
- busy_o = any full flag | (state≠IDLE).

Decomposition:
- Shared package npu_pkg: WR_CYC_NUM/RD_SPARSEMAP_NUM derivations, FSM state enum (IDLE/START/RUN).
- One sub-module, bank_writer, instantiated twice (IFM, filter). It holds the counter, wr_sel, full[2], output registers, and takes a release pulse plus release bank index.

Test Plan (MEM_SIZE=128, BUS_SIZE=32 → WR_CYC_NUM=4):
- Single chunk:
  - Stimulus: 4 IFM and 4 filter beats back-to-back from cycle 1 (data byte = beat index).
  - Required: wr_valid_o at cycles 2–5 with wr_count 0,1,2,3 and wr_sel_o=0; chunk_start_o at cycle 6; run_valid_o 6..end; chunk_end_i at 20 → run_valid_o=0 at 21, rd_sel_o=1.
- Skew:
  - Stimulus: filter beats arrive 10 cycles after IFM.
  - Required: no chunk_start_o until 2 cycles after the last filter beat; no IFM bank-0 overwrite.
- Ping-pong:
  - Stimulus: 3 chunks streamed continuously; chunk_end_i 30 cycles after each start.
  - Required: chunk 2 written to bank 1 during chunk-1 RUN; ready_o=0 while both banks full; chunks are started in order with rd_sel 0,1,0.
- Config latch:
  - Stimulus: cfg_rd_sparsemap_last_i=3 at start, changed to 1 during RUN.
  - Required: rd_sparsemap_last_o stays 3 until the next START.
- Spurious end:
  - Stimulus: chunk_end_i pulsed in IDLE.
  - Required: no flag clear, rd_sel unchanged.
- Reset mid-op:
  - Stimulus: rst_i asserted in RUN with bank 1 half written.
  - Required: next cycle all outputs 0, ready_o=1, wr_count restarts at 0 on bank 0.
